// File: rtl/wb_serializer_pkg.sv
// Shared constants and types for the serializer Wishbone blocks.
package wb_serializer_pkg;

  localparam logic [31:0] ADR_WRITE = 32'h0000_0004;

  localparam logic [8:0] SOF_K  = 9'h11C;
  localparam logic [8:0] EOF_K  = 9'h1FD;
  localparam logic [8:0] IDLE_K = 9'h1BC;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_FILL,
    TX_BUS,
    TX_DRAIN
  } tx_sched_state_t;

  typedef enum logic [1:0] {
    PH_PAYLOAD,
    PH_EOF,
    PH_PAD
  } tx_phase_t;

  // Slot 0 is transmitted first and occupies the highest symbol field.
  function automatic logic [31:0] place_sym(input logic [31:0] word,
                                            input logic [1:0]  slot,
                                            input logic [8:0]  sym);
    logic [31:0] w;
    w        = word;
    w[31:27] = '0;
    case (slot)
      2'd0:    w[26:18] = sym;
      2'd1:    w[17:9]  = sym;
      default: w[8:0]   = sym;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/wb_serializer_tx_sched_if.sv
// Requester byte streams plus the Wishbone master bus of the TX scheduler.
interface wb_serializer_tx_sched_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [NUM_REQ*8-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_last_i;
  logic [NUM_REQ-1:0]   req_ready_o;

  logic                 CYC_O;
  logic                 STB_O;
  logic                 WE_O;
  logic [31:0]          ADR_O;
  logic [31:0]          DAT_O;
  logic                 ACK_I;
  logic                 ERR_I;

  modport master (
    input  req_valid_i, req_data_i, req_last_i, ACK_I, ERR_I,
    output req_ready_o, CYC_O, STB_O, WE_O, ADR_O, DAT_O
  );

  modport slave (
    output req_valid_i, req_data_i, req_last_i, ACK_I, ERR_I,
    input  req_ready_o, CYC_O, STB_O, WE_O, ADR_O, DAT_O
  );
endinterface

// File: rtl/wb_serializer_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, with wrap.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o
);

  logic          found;
  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand     = (32'(ptr_i) + k) % NUM_REQ;
      cand_idx = IW'(cand);
      if (!found && req_i[cand_idx]) begin
        found             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/wb_serializer_tx_sched.sv
// Frames requester byte streams into 9-bit symbols, packs three per word and
// writes each word to the serializer over Wishbone, one frame owner at a time.
module wb_serializer_tx_sched
  import wb_serializer_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ACK_TIMEOUT = 4096
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  wb_serializer_tx_sched_if.master bus,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic                     err_o
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  tx_sched_state_t    state_q, state_d;
  tx_phase_t          phase_q, phase_d;
  logic [1:0]         slot_q, slot_d;
  logic               eof_q, eof_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               cyc_q, cyc_d;
  logic [31:0]        dat_q, dat_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic [IW-1:0]      ptr_next;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic [NUM_REQ-1:0] ready;
  logic               place;
  logic [8:0]         sym;
  logic               done_pulse;
  logic               err_pulse;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (bus.req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

  assign sel_valid = bus.req_valid_i[gidx_q];
  assign sel_last  = bus.req_last_i[gidx_q];
  assign sel_data  = bus.req_data_i[{gidx_q, 3'b000} +: 8];
  assign ptr_next  = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    slot_d     = slot_q;
    eof_d      = eof_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    dat_d      = dat_q;
    ready      = '0;
    place      = 1'b0;
    sym        = '0;
    done_pulse = 1'b0;
    err_pulse  = 1'b0;

    case (state_q)
      TX_IDLE: begin
        if (|bus.req_valid_i) begin
          grant_d = arb_grant;
          gidx_d  = arb_idx;
          dat_d   = place_sym(dat_q, 2'd0, SOF_K);
          phase_d = PH_PAYLOAD;
          eof_d   = 1'b0;
          slot_d  = 2'd1;
          state_d = TX_FILL;
        end
      end

      TX_FILL: begin
        case (phase_q)
          PH_PAYLOAD: begin
            ready[gidx_q] = 1'b1;
            if (sel_valid) begin
              place = 1'b1;
              sym   = {1'b0, sel_data};
              if (sel_last) phase_d = PH_EOF;
            end
          end
          PH_EOF: begin
            place   = 1'b1;
            sym     = EOF_K;
            eof_d   = 1'b1;
            phase_d = PH_PAD;
          end
          default: begin
            place = 1'b1;
            sym   = IDLE_K;
          end
        endcase
        if (place) begin
          dat_d = place_sym(dat_q, slot_q, sym);
          if (slot_q == 2'd2) begin
            cyc_d   = 1'b1;
            cnt_d   = '0;
            state_d = TX_BUS;
          end else begin
            slot_d = slot_q + 2'd1;
          end
        end
      end

      TX_BUS: begin
        // Error and timeout take priority over a simultaneous ACK.
        if (bus.ERR_I || (cnt_q == CNT_LAST)) begin
          err_pulse = 1'b1;
          cyc_d     = 1'b0;
          if (eof_q) begin
            ptr_d   = ptr_next;
            grant_d = '0;
            state_d = TX_IDLE;
          end else begin
            state_d = TX_DRAIN;
          end
        end else if (bus.ACK_I) begin
          cyc_d = 1'b0;
          if (eof_q) begin
            done_pulse = 1'b1;
            ptr_d      = ptr_next;
            grant_d    = '0;
            state_d    = TX_IDLE;
          end else begin
            slot_d  = 2'd0;
            state_d = TX_FILL;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      TX_DRAIN: begin
        ready[gidx_q] = 1'b1;
        if (sel_valid && sel_last) begin
          ptr_d   = ptr_next;
          grant_d = '0;
          state_d = TX_IDLE;
        end
      end

      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= TX_IDLE;
      phase_q <= PH_PAYLOAD;
      slot_q  <= '0;
      eof_q   <= 1'b0;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      slot_q  <= slot_d;
      eof_q   <= eof_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      dat_q   <= dat_d;
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.CYC_O       = cyc_q;
  assign bus.STB_O       = cyc_q;
  assign bus.WE_O        = cyc_q;
  assign bus.ADR_O       = ADR_WRITE;
  assign bus.DAT_O       = dat_q;

  assign grant_o      = grant_q;
  assign busy_o       = (state_q != TX_IDLE);
  assign frame_done_o = done_pulse;
  assign err_o        = err_pulse;

endmodule

// File: tb/tb_wb_serializer_tx_sched.sv
// Scoreboard bench for wb_serializer_tx_sched: requester queues, auto-responding slave.
module tb_wb_serializer_tx_sched;
  import wb_serializer_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] grant;
  logic          busy, fdone, errp;

  wb_serializer_tx_sched_if #(.NUM_REQ(NR)) bus ();

  wb_serializer_tx_sched #(
    .NUM_REQ     (NR),
    .ACK_TIMEOUT (TO)
  ) dut (
    .CLK_I        (clk),
    .RST_I        (rst),
    .bus          (bus),
    .grant_o      (grant),
    .busy_o       (busy),
    .frame_done_o (fdone),
    .err_o        (errp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [8:0]  rq [NR][$];
  logic [31:0] expw [$];
  int          glog [$];
  logic [NR-1:0] rdy_s = '0;
  int fd_cnt = 0, err_cnt = 0, cyc_hi = 0, wr_cnt = 0;
  int cyc_no = 0, t_valid = 0, t_cyc = 0;
  int resp_mode = 0;  // 0: ACK, 1: ACK+ERR once, 2: no response
  bit in_wr = 0;

  function automatic logic [31:0] pk(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c);
    return {5'b0, a, b, c};
  endfunction

  // Requester driver: pops a byte on handshake, presents the next one after the edge.
  initial begin
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.req_last_i  = '0;
    forever begin
      @(posedge clk);
      for (int n = 0; n < NR; n++)
        if (!rst && bus.req_valid_i[n] && rdy_s[n] && rq[n].size() > 0) void'(rq[n].pop_front());
      #1;
      for (int n = 0; n < NR; n++) begin
        if (rq[n].size() > 0) begin
          bus.req_valid_i[n]       = 1'b1;
          bus.req_data_i[8*n +: 8] = rq[n][0][7:0];
          bus.req_last_i[n]        = rq[n][0][8];
        end else begin
          bus.req_valid_i[n] = 1'b0;
          bus.req_last_i[n]  = 1'b0;
        end
      end
    end
  end

  // Slave responder and monitor, sampling between clock edges.
  initial begin
    logic [31:0]   w;
    logic [NR-1:0] prev_grant;
    logic          prev_cyc, prev_val;
    prev_grant = '0;
    prev_cyc   = 1'b0;
    prev_val   = 1'b0;
    bus.ACK_I  = 1'b0;
    bus.ERR_I  = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ACK_I || bus.ERR_I) begin
        bus.ACK_I = 1'b0;
        bus.ERR_I = 1'b0;
      end else if (bus.CYC_O && bus.STB_O && !in_wr) begin
        in_wr = 1;
        wr_cnt++;
        total++;
        if (expw.size() == 0) begin
          bad++;
          $display("FAIL write_unexpected got DAT_O=%h exp=none", bus.DAT_O);
        end else begin
          w = expw.pop_front();
          if ({bus.WE_O, bus.ADR_O, bus.DAT_O} !== {1'b1, ADR_WRITE, w}) begin
            bad++;
            $display("FAIL write_word got WE=%b ADR=%h DAT=%h exp WE=1 ADR=%h DAT=%h",
                     bus.WE_O, bus.ADR_O, bus.DAT_O, ADR_WRITE, w);
          end
        end
        if (resp_mode == 0) bus.ACK_I = 1'b1;
        else if (resp_mode == 1) begin
          bus.ACK_I = 1'b1;
          bus.ERR_I = 1'b1;
          resp_mode = 0;
        end
      end
      #1;
      cyc_no++;
      if (bus.CYC_O) cyc_hi++;
      else in_wr = 0;
      if (bus.CYC_O && !prev_cyc) t_cyc = cyc_no;
      if ((bus.req_valid_i != 0) && !prev_val) t_valid = cyc_no;
      prev_cyc = bus.CYC_O;
      prev_val = (bus.req_valid_i != 0);
      fd_cnt  += int'(fdone);
      err_cnt += int'(errp);
      rdy_s = bus.req_ready_o;
      if (grant != 0 && prev_grant == 0) glog.push_back($clog2(grant));
      prev_grant = grant;
      if (grant != 0 || bus.req_ready_o != 0) begin
        total++;
        if (((bus.req_ready_o & ~grant) != 0) || !$onehot0(grant)) begin
          bad++;
          $display("FAIL ready_grant got ready=%b grant=%b exp ready within one-hot grant",
                   bus.req_ready_o, grant);
        end
      end
    end
  end

  task automatic push_bytes(input int n, input logic [7:0] first, input int len);
    for (int i = 0; i < len; i++) rq[n].push_back({(i == len - 1), 8'(first + 8'(i))});
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    int pend;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      #2;
      pend = 0;
      for (int n = 0; n < NR; n++) pend += rq[n].size();
      done = (pend == 0) && !busy && !bus.CYC_O;
    end
    total++;
    if (!done) begin bad++; $display("FAIL %s_timeout got busy=%b exp idle", name, busy); end
    total++;
    if (expw.size() != 0) begin bad++; $display("FAIL %s_missing got pending=%0d exp=0", name, expw.size()); end
  endtask

  task automatic check_order(input string name, input int g0, input int a, input int b);
    total++;
    if (glog.size() < g0 + 2) begin
      bad++;
      $display("FAIL %s got grants=%0d exp=2", name, glog.size() - g0);
    end else if (glog[g0] != a || glog[g0+1] != b) begin
      bad++;
      $display("FAIL %s got %0d,%0d exp %0d,%0d", name, glog[g0], glog[g0+1], a, b);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #2;
    total++;
    if ({bus.CYC_O, bus.STB_O, bus.WE_O} !== 3'b000) begin
      bad++; $display("FAIL reset_strobes got %b exp 000", {bus.CYC_O, bus.STB_O, bus.WE_O});
    end
    total++;
    if ({bus.ADR_O, bus.DAT_O} !== {ADR_WRITE, 32'h0}) begin
      bad++; $display("FAIL reset_adr_dat got %h %h exp %h 0", bus.ADR_O, bus.DAT_O, ADR_WRITE);
    end
    total++;
    if ({grant, busy, fdone, errp, bus.req_ready_o} !== '0) begin
      bad++; $display("FAIL reset_status got grant=%b busy=%b ready=%b exp 0", grant, busy, bus.req_ready_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int g0 = glog.size();
    int f0 = fd_cnt;
    for (int n = 0; n < NR; n++) push_bytes(n, 8'(8'h10 + n), 1);
    push_bytes(0, 8'h20, 1);
    for (int n = 0; n < NR; n++) expw.push_back(pk(SOF_K, {1'b0, 8'(8'h10 + n)}, EOF_K));
    expw.push_back(pk(SOF_K, 9'h020, EOF_K));
    wait_idle("rr");
    total++;
    if (glog.size() != g0 + 5) begin
      bad++; $display("FAIL rr_grants got=%0d exp=5", glog.size() - g0);
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (glog[g0+i] != exp_order[i]) begin
          bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, glog[g0+i], exp_order[i]);
        end
      end
    end
    total++;
    if (fd_cnt - f0 != 5) begin bad++; $display("FAIL rr_frame_done got=%0d exp=5", fd_cnt - f0); end
  endtask

  task automatic test_two_byte();
    int f0 = fd_cnt;
    int g0;
    push_bytes(0, 8'h01, 2);
    expw.push_back(pk(SOF_K, 9'h001, 9'h002));
    expw.push_back(pk(EOF_K, IDLE_K, IDLE_K));
    wait_idle("two_byte");
    total++;
    if (fd_cnt - f0 != 1) begin bad++; $display("FAIL two_byte_done got=%0d exp=1", fd_cnt - f0); end
    // Pointer is now 1, so requester 1 wins over requester 0.
    g0 = glog.size();
    push_bytes(0, 8'h40, 1);
    push_bytes(1, 8'h41, 1);
    expw.push_back(pk(SOF_K, 9'h041, EOF_K));
    expw.push_back(pk(SOF_K, 9'h040, EOF_K));
    wait_idle("two_byte_ptr");
    check_order("two_byte_ptr_order", g0, 1, 0);
  endtask

  task automatic test_single();
    int f0 = fd_cnt;
    int e0 = err_cnt;
    int w0 = wr_cnt;
    push_bytes(1, 8'hA5, 1);
    expw.push_back(32'h04714BFD);
    wait_idle("single");
    total++;
    if (fd_cnt - f0 != 1 || err_cnt != e0 || wr_cnt - w0 != 1) begin
      bad++; $display("FAIL single_counts got done=%0d err=%0d wr=%0d exp 1 0 1",
                      fd_cnt - f0, err_cnt - e0, wr_cnt - w0);
    end
    total++;
    if (t_cyc - t_valid != 3) begin bad++; $display("FAIL single_latency got=%0d exp=3", t_cyc - t_valid); end
  endtask

  task automatic test_err_drain();
    int f0 = fd_cnt;
    int e0 = err_cnt;
    int w0 = wr_cnt;
    int g0;
    resp_mode = 1;
    push_bytes(2, 8'h30, 5);
    expw.push_back(pk(SOF_K, 9'h030, 9'h031));
    wait_idle("err");
    total++;
    if (err_cnt - e0 != 1) begin bad++; $display("FAIL err_pulse got=%0d exp=1", err_cnt - e0); end
    total++;
    if (fd_cnt != f0 || wr_cnt - w0 != 1) begin
      bad++; $display("FAIL err_drain got done=%0d wr=%0d exp 0 1", fd_cnt - f0, wr_cnt - w0);
    end
    g0 = glog.size();
    push_bytes(0, 8'h50, 1);
    push_bytes(3, 8'h53, 1);
    expw.push_back(pk(SOF_K, 9'h053, EOF_K));
    expw.push_back(pk(SOF_K, 9'h050, EOF_K));
    wait_idle("err_ptr");
    check_order("err_ptr_order", g0, 3, 0);
  endtask

  task automatic test_timeout();
    int f0 = fd_cnt;
    int e0 = err_cnt;
    int c0 = cyc_hi;
    resp_mode = 2;
    push_bytes(1, 8'h66, 1);
    expw.push_back(pk(SOF_K, 9'h066, EOF_K));
    wait_idle("timeout");
    total++;
    if (cyc_hi - c0 != int'(TO)) begin bad++; $display("FAIL timeout_len got=%0d exp=%0d", cyc_hi - c0, TO); end
    total++;
    if (err_cnt - e0 != 1 || fd_cnt != f0) begin
      bad++; $display("FAIL timeout_err got err=%0d done=%0d exp 1 0", err_cnt - e0, fd_cnt - f0);
    end
    resp_mode = 0;
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    int g0;
    resp_mode = 2;
    push_bytes(2, 8'h77, 1);
    expw.push_back(pk(SOF_K, 9'h077, EOF_K));
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #2;
      seen = bus.CYC_O;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL rst_mid_bus got CYC=0 exp 1"); end
    rst = 1'b1;
    #1;
    total++;
    if ({bus.CYC_O, bus.STB_O, busy, grant} !== '0) begin
      bad++; $display("FAIL rst_mid_async got CYC=%b STB=%b busy=%b grant=%b exp 0",
                      bus.CYC_O, bus.STB_O, busy, grant);
    end
    for (int n = 0; n < NR; n++) rq[n].delete();
    expw.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    resp_mode = 0;
    g0 = glog.size();
    push_bytes(0, 8'h80, 1);
    push_bytes(3, 8'h83, 1);
    expw.push_back(pk(SOF_K, 9'h080, EOF_K));
    expw.push_back(pk(SOF_K, 9'h083, EOF_K));
    wait_idle("rst_mid");
    check_order("rst_mid_order", g0, 0, 3);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_two_byte();
    test_single();
    test_err_drain();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion exp finish");
    $fatal(1, "watchdog");
  end

endmodule
